// File: rtl/mul_tree_result_collector_pkg.sv
// Shared types and helpers for the multiplier-tree result collector.
package mul_tree_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        MODE_4L  = 2'b00,
        MODE_2L  = 2'b01,
        MODE_1L  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // Lanes that carry results for a given tree mode; reserved behaves as 4-lane.
    function automatic logic [LANES-1:0] exp_mask(input mode_e m);
        case (m)
            MODE_2L: exp_mask = 4'b0011;
            MODE_1L: exp_mask = 4'b0001;
            default: exp_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mul_tree_result_collector_if.sv
// Downstream valid/ready result stream carrying one packed lane group per beat.
interface mul_tree_result_collector_if;
    import mul_tree_pkg::*;

    logic [LANES*DW-1:0] res_data;
    logic [LANES-1:0]    res_mask;
    logic                res_valid;
    logic                res_ready;

    modport master (output res_data, output res_mask, output res_valid, input  res_ready);
    modport slave  (input  res_data, input  res_mask, input  res_valid, output res_ready);

endinterface

// File: rtl/mul_tree_result_collector_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 68,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // Handshake qualification and head-of-queue presentation.
    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem[rd_ptr];
        level   = cnt;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
            else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_tree_result_collector.sv
// Collects per-lane tree results arriving on arbitrary cycles into packed
// groups and queues them for a valid/ready consumer.
module mul_tree_result_collector
    import mul_tree_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic [LANES*DW-1:0]         tree_outputs,
    input  logic [LANES-1:0]            tree_stbs,
    mul_tree_result_collector_if.master res,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic                        collision,
    output logic [7:0]                  drop_cnt
);
    localparam int unsigned WIDTH = LANES*DW + LANES;

    logic [LANES-1:0]    got;
    logic [LANES-1:0]    exp_q;
    logic [DW-1:0]       cap [LANES];
    logic [LANES-1:0]    cur_exp;
    logic [LANES-1:0]    hit;
    logic                complete;
    logic [LANES*DW-1:0] group_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [WIDTH-1:0]    fifo_rdata;

    // Expected lanes follow mode only while idle; completed group merges this cycle's lanes.
    always_comb begin
        cur_exp    = (got == '0) ? exp_mask(mode_e'(mode)) : exp_q;
        hit        = tree_stbs & cur_exp;
        complete   = ((got | hit) == cur_exp);
        group_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (cur_exp[i])
                group_data[i*DW +: DW] = hit[i] ? tree_outputs[i*DW +: DW] : cap[i];
        end
        fifo_pop = res.res_valid && res.res_ready;
    end

    // Lane capture, arrival tracking and collision detection for the open group.
    always_ff @(posedge clk) begin
        if (rst) begin
            got       <= '0;
            exp_q     <= '0;
            collision <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) cap[i] <= '0;
        end else begin
            exp_q <= cur_exp;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (hit[i]) cap[i] <= tree_outputs[i*DW +: DW];
            end
            if ((hit & got) != '0) collision <= 1'b1;
            got <= complete ? '0 : (got | hit);
        end
    end

    // Drop accounting for groups that complete while the FIFO is full and not draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (complete && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (complete),
        .pop   (fifo_pop),
        .wdata ({cur_exp, group_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign res.res_valid = !fifo_empty;
    assign res.res_data  = fifo_rdata[LANES*DW-1:0];
    assign res.res_mask  = fifo_rdata[WIDTH-1 -: LANES];

endmodule
